// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int MAX_W     = 64;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Magnitude of a w-bit operand (two's complement when s=1), returned zero-extended.
  // The most negative value maps to 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v, input logic s,
                                             input int w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] r;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    r    = v & mask;
    if (s && r[6'(w - 1)]) r = (~r + MAX_W'(1)) & mask;
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Start/done handshake bundle between a requesting controller and seq_mul.
interface seq_mul_if
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod;

  modport master (output start, sgn, a_in, b_in, input busy, done, prod);
  modport slave  (input start, sgn, a_in, b_in, output busy, done, prod);
endinterface

// File: rtl/seq_mul_ctrl.sv
// Sequencing FSM for seq_mul; the datapath reports bm==0 through bz.
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | one shift-and-add step per cycle until the multiplier is exhausted
//   FIX   | apply result sign and latch prod
//   DONE  | one-cycle completion pulse; accepts a new start
module seq_mul_ctrl
  import mul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bz,
  output logic load,
  output logic step,
  output logic fix,
  output logic busy,
  output logic done
);

  state_t state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (bz) state_nxt = FIX;
        else    step      = 1'b1;
      end
      FIX: begin
        busy      = 1'b1;
        fix       = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-and-add multiplier, signed/unsigned, with early exit on a zero multiplier.
module seq_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  seq_mul_if.slave  bus
);

  logic [2*WIDTH-1:0] am;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   bm;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               neg;
  logic               load, step, fix, bz;

  assign a_abs = WIDTH'(abs_w(MAX_W'(bus.a_in), bus.sgn, WIDTH));
  assign b_abs = WIDTH'(abs_w(MAX_W'(bus.b_in), bus.sgn, WIDTH));
  assign bz    = (bm == '0);

  seq_mul_ctrl u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start),
    .bz    (bz),
    .load  (load),
    .step  (step),
    .fix   (fix),
    .busy  (bus.busy),
    .done  (bus.done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      am     <= '0;
      bm     <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      prod_r <= '0;
    end else begin
      if (load) begin
        am  <= {{WIDTH{1'b0}}, a_abs};
        bm  <= b_abs;
        acc <= '0;
        neg <= bus.sgn & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
      end else if (step) begin
        if (bm[0]) acc <= acc + am;
        am <= am << 1;
        bm <= bm >> 1;
      end
      if (fix) prod_r <= neg ? (~acc + 1'b1) : acc;
    end
  end

  assign bus.prod = prod_r;

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: stimulus pushes expected products, a negedge monitor checks them.
module tb_seq_mul;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] p;
    longint         t;
    int             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  exp_t q[$];
  logic [2*W-1:0] held = '0;
  logic prev_done = 1'b0;

  seq_mul_if #(.WIDTH(W)) bus ();

  seq_mul #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model_prod(input logic s, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(pa * pb);
  endfunction

  function automatic int model_lat(input logic s, input logic [W-1:0] b);
    longint mb;
    int m;
    mb = s ? longint'($signed(b)) : longint'(b);
    if (mb < 0) mb = -mb;
    m = 0;
    while (mb > 0) begin
      m++;
      mb = mb >> 1;
    end
    return m + 2;
  endfunction

  task automatic push_exp(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.p   = model_prod(s, a, b);
    e.t   = longint'($time);
    e.lat = model_lat(s, b);
    q.push_back(e);
  endtask

  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("issue_wait_timeout", 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    push_exp(s, a, b);
    #1 bus.start = 1'b0;
  endtask

  // Start issued in the DONE cycle of the operation currently in flight.
  task automatic issue_at_done(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_wait_timeout", 64'(bus.done), 64'd1);
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk);
    push_exp(s, a, b);
    #1 bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held      = '0;
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        if (prev_done) chk("done_single_cycle", 64'(prev_done), 64'd0);
        chk("busy_low_at_done", 64'(bus.busy), 64'd0);
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(q.size()), 64'd1);
        end else begin
          exp_t e;
          int lat;
          e   = q.pop_front();
          lat = int'((longint'($time) - e.t - 5) / 10);
          chk("prod", 64'(bus.prod), 64'(e.p));
          chk("latency", 64'(lat), 64'(e.lat));
          held = e.p;
        end
      end else begin
        chk("prod_hold", 64'(bus.prod), 64'(held));
        if (q.size() > 0 && (longint'($time) - q[0].t) > longint'((W + 8) * 10)) begin
          chk("done_timeout", 64'(bus.done), 64'd1);
          void'(q.pop_front());
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin
    int n;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    #2;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_prod", 64'(bus.prod), 64'd0);
    #10 rst = 1'b0;

    issue(1'b0, 16'd10, 16'd5);
    issue(1'b0, 16'd1234, 16'd0);
    issue(1'b0, 16'd0, 16'hFFFF);
    issue(1'b1, 16'hFFFD, 16'd7);
    issue(1'b1, 16'h8000, 16'h8000);
    issue(1'b0, 16'hFFFF, 16'hFFFF);
    issue(1'b1, 16'd7, 16'hFFFD);
    issue(1'b1, 16'h7FFF, 16'h8000);

    // Starts while busy must be ignored.
    issue(1'b0, 16'h1234, 16'hFFFF);
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.a_in  = 16'd5;
      bus.b_in  = 16'd5;
    end
    @(negedge clk) bus.start = 1'b0;

    issue_at_done(1'b0, 16'd2, 16'd3);
    issue_at_done(1'b1, 16'hFFFF, 16'hFFFF);

    // Asynchronous reset in the middle of CALC.
    issue(1'b0, 16'hFFFF, 16'hFFFF);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_done", 64'(bus.done), 64'd0);
    chk("async_rst_prod", 64'(bus.prod), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    issue(1'b0, 16'd6, 16'd7);

    for (int i = 0; i < 200; i++) begin
      logic s;
      logic [W-1:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom & ((32'd1 << $urandom_range(0, W)) - 1));
      if ($urandom_range(0, 3) == 0) begin
        issue_at_done(s, a, b);
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(s, a, b);
      end
    end

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised sequential shift-and-add multiplier with a start/done handshake. It supersedes the fixed 16-bit repeated-addition multiplier, which had a separate datapath and controller. Changes from that design:
- runtime-selectable signed/unsigned mode;
- early termination once the remaining multiplier bits are zero;
- full double-width product.

It sits as a shared arithmetic unit behind any controller that can issue a one-cycle start and wait for done.

## Interface

- WIDTH, 16, operand width in bits (≥2); product is 2*WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a_in  in  WIDTH  multiplicand; sampled with start.
- b_in  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high in CALC and FIX.
- done  out  1  one-cycle pulse, high in DONE.
- prod  out  2*WIDTH  result register; updated only on FIX→DONE; holds otherwise.

## Operation

- State machine: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start=1 → CALC. The same edge loads:
  - am = zero-extended |a_in| to 2*WIDTH bits;
  - bm = |b_in| (WIDTH bits);
  - acc = 0;
  - neg = sgn & (a_in[MSB] ^ b_in[MSB]).
- When sgn=0, magnitudes are the raw operands. |−2^(WIDTH−1)| = 2^(WIDTH−1) as an unsigned WIDTH-bit value, with no overflow.
- CALC, bm≠0:
  - if bm[0], acc += am (2*WIDTH-bit add, no carry out possible);
  - am <<= 1; bm >>= 1; stay in CALC.
- CALC, bm==0 → FIX; no update that cycle.
- FIX: prod ← neg ? −acc : acc (2*WIDTH two's complement); → DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 → CALC (back-to-back);
  - otherwise → IDLE.
- start while busy is ignored; no queuing, no error flag.
- Reset at any time: state IDLE, busy=0, done=0, prod=0, internal registers 0. An in-flight operation is discarded.

## Timing

- Let m = number of significant bits of the multiplier magnitude: 0 for b=0, and bit index of the highest set bit + 1 otherwise.
- Start sampled at edge k:
  - CALC during cycles k+1 … k+m+1;
  - FIX at edge k+m+1 → k+m+2;
  - done high and prod valid after edge k+m+2.
- Latency (start edge to done) = m+2 edges, i.e. 2 minimum (b=0) and WIDTH+2 maximum.
- busy rises after edge k and falls after edge k+m+2, in the same cycle done rises.
- Throughput with back-to-back starts: one result per m+3 cycles (DONE counts as the accept cycle).
- prod is stable from done until the next FIX→DONE, and through IDLE.

## Structure

- Package mul_pkg holds:
  - state enum (IDLE, CALC, FIX, DONE);
  - default WIDTH constant;
  - helper function for WIDTH-bit absolute value.
- Split the design as before:
  - top seq_mul holds the datapath (am, bm, acc, prod, neg, adder, shifters, sign fix);
  - sub-module seq_mul_ctrl holds the FSM, with inputs start and bz (bm==0) and outputs load, step, fix, busy, done.
- Expected size: ~150–250 lines total.

## Test plan

- Unsigned: WIDTH=16, sgn=0, a=10, b=5, start at edge k → after edge k+5, done=1 for one cycle, prod=50, busy low from that cycle.
- Zero / early exit: a=1234, b=0 → done after 2 edges, prod=0. Then a=0, b=0xFFFF → done after 18 edges, prod=0.
- Signed: sgn=1, a=−3 (0xFFFD), b=7 → prod=0xFFFFFFEB, latency 5. Also a=0x8000, b=0x8000, sgn=1 → prod=0x40000000, latency 18.
- Unsigned max: a=b=0xFFFF, sgn=0 → prod=0xFFFE0001, latency 18.
- Handshake:
  - start pulses during CALC are ignored and prod is unchanged by them;
  - start asserted in the DONE cycle with a=2, b=3 → CALC next, prod=6 after 4 more edges;
  - previous prod holds until then.
- Reset: assert rst asynchronously mid-CALC (between edges) → busy, done and prod go to 0 immediately. After release, a fresh start with a=6, b=7 → prod=42.
